data_memory: RTL and testbench

- Parametrised single-port data memory for the MIPS datapath.
- Adds byte-lane write enables, a registered read with a valid strobe, and a request/ready handshake.
- After reset, a hardware init sequencer loads every word with its own index. The array is never trusted until that sweep completes.
- Sits on the load/store path behind the execute stage; instruction fetch may instantiate it with writes tied off.

---
 rtl/memory_pkg.sv | 27 ++
 rtl/memory_array.sv | 80 ++++++++
 rtl/data_memory.sv | 105 ++++++++++
 tb/tb_data_memory.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_pkg
// Description : Shared types and helpers for the data memory. It holds the
//               init FSM state encoding, the byte-lane count helper, and the
//               selector for the fill pattern that the init sweep writes.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_pkg;

    // Init sequencer states. READY is terminal until the next reset.
    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Fill pattern used by the init sweep: 0 = each word gets its own index,
    // any other value = all-zero fill.
    localparam int INIT_PATTERN_INDEX = 0;

    // Returns the number of byte lanes in one memory word.
    function automatic int bytes_per_word(input int word_size);
        return word_size / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_array.sv
`default_nettype none
// ============================================================================
// Module      : memory_array
// Description : Byte-lane-enabled single-port storage with one read port.
//               The read is registered with a valid strobe by default. When
//               MEMORY_ASYNC_READ_EN is defined, the read is combinational
//               and valid follows the read request in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_array
    import memory_pkg::*;
#(
    parameter int ADDR_SIZE = 5,
    parameter int WORD_SIZE = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   we_i,
    input  logic [WORD_SIZE/8-1:0] be_i,
    input  logic [ADDR_SIZE-1:0]   addr_i,
    input  logic [WORD_SIZE-1:0]   wdata_i,
    input  logic                   re_i,
    output logic [WORD_SIZE-1:0]   rdata_o,
    output logic                   rvalid_o
);

    localparam int NUM_BYTES = bytes_per_word(WORD_SIZE);
    localparam int DEPTH     = 2 ** ADDR_SIZE;

    // The storage has no reset, so synthesis can map it onto block RAM.
    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    // Byte-lane write: only the enabled lanes of the addressed word change.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (be_i[k]) begin
                    mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

`ifdef MEMORY_ASYNC_READ_EN
    // Reset has no effect on a combinational read path.
    logic unused_rst_n;
    assign unused_rst_n = rst_ni;

    assign rdata_o  = mem_q[addr_i];
    assign rvalid_o = re_i;
`else
    logic [WORD_SIZE-1:0] rdata_d, rdata_q;
    logic                 rvalid_d, rvalid_q;

    // Capture read data on a read and keep the previous value otherwise.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = re_i;
        if (re_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    // Read output register. Reset drops any pending strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
`endif

endmodule
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Single-port data memory for the MIPS load/store path. After
//               reset, an init sequencer writes every word with its own
//               index. Requests are accepted only after that sweep finishes.
//               Config macro: MEMORY_ASYNC_READ_EN (combinational read).
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory
    import memory_pkg::*;
#(
    parameter int ADDR_SIZE = 5,
    parameter int WORD_SIZE = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   wen_i,
    input  logic [WORD_SIZE/8-1:0] be_i,
    input  logic [ADDR_SIZE-1:0]   addr_i,
    input  logic [WORD_SIZE-1:0]   data_i,
    output logic                   ready_o,
    output logic                   valid_o,
    output logic [WORD_SIZE-1:0]   data_o
);

    if (WORD_SIZE % 8 != 0) begin : g_word_size_check
        $error("data_memory: WORD_SIZE must be a multiple of 8");
    end

    state_e               state_d, state_q;
    logic [ADDR_SIZE-1:0] cnt_d, cnt_q;

    logic                   in_init;
    logic                   accept;
    logic                   arr_we;
    logic                   arr_re;
    logic [WORD_SIZE/8-1:0] arr_be;
    logic [ADDR_SIZE-1:0]   arr_addr;
    logic [WORD_SIZE-1:0]   arr_wdata;
    logic [WORD_SIZE-1:0]   init_word;

    assign in_init = (state_q == INIT);
    assign accept  = req_i && !in_init;
    assign ready_o = !in_init;

    // Sweep advances one word per cycle and leaves INIT after the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (in_init) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {ADDR_SIZE{1'b1}}) begin
                state_d = READY;
            end
        end
    end

    // Init FSM and sweep counter. Reset restarts the sweep from address 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Route the array port from the sequencer during INIT, or from the
    // request ports once ready.
    always_comb begin
        init_word = (INIT_PATTERN_INDEX == 0) ? WORD_SIZE'(cnt_q) : '0;
        arr_we    = accept && wen_i;
        arr_re    = accept && !wen_i;
        arr_be    = be_i;
        arr_addr  = addr_i;
        arr_wdata = data_i;
        if (in_init) begin
            arr_we    = 1'b1;
            arr_re    = 1'b0;
            arr_be    = '1;
            arr_addr  = cnt_q;
            arr_wdata = init_word;
        end
    end

    memory_array #(
        .ADDR_SIZE (ADDR_SIZE),
        .WORD_SIZE (WORD_SIZE)
    ) u_array (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .we_i     (arr_we),
        .be_i     (arr_be),
        .addr_i   (arr_addr),
        .wdata_i  (arr_wdata),
        .re_i     (arr_re),
        .rdata_o  (data_o),
        .rvalid_o (valid_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory
// Description : Directed self-checking bench for data_memory (ADDR_SIZE=5,
//               WORD_SIZE=32). Inputs are driven on the falling edge, and
//               outputs are sampled on the falling edge after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

    localparam int ADDR_SIZE = 5;
    localparam int WORD_SIZE = 32;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        req    = 1'b0;
    logic        wen    = 1'b0;
    logic [3:0]  be     = 4'h0;
    logic [4:0]  addr   = '0;
    logic [31:0] wdata  = '0;
    logic        ready;
    logic        valid;
    logic [31:0] rdata;

    int n_vec = 0;
    int n_err = 0;

    data_memory #(
        .ADDR_SIZE (ADDR_SIZE),
        .WORD_SIZE (WORD_SIZE)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .wen_i   (wen),
        .be_i    (be),
        .addr_i  (addr),
        .data_i  (wdata),
        .ready_o (ready),
        .valid_o (valid),
        .data_o  (rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at the falling edge where reset is released. It keeps poking
    // requests (alternating write/read to addr 9) and counts the cycles with
    // ready low and any valid seen during the sweep.
    task automatic wait_ready(input string tag);
        int lows;
        int vseen;
        lows  = 0;
        vseen = 0;
        while (!ready && lows < 200) begin
            req   = 1'b1;
            wen   = ~lows[0];
            be    = 4'hF;
            addr  = 5'd9;
            wdata = 32'hFFFF_FFFF;
            lows++;
            @(negedge clk);
            if (valid) vseen++;
        end
        req = 1'b0;
        wen = 1'b0;
        check_val({tag, "_cycles"}, lows, 32);
        check_val({tag, "_valid"}, vseen, 0);
    endtask

    // Starts and ends at a falling edge.
    task automatic do_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
        req  = 1'b1;
        wen  = 1'b0;
        addr = a;
`ifdef MEMORY_ASYNC_READ_EN
        #1;
        check_val({tag, "_valid"}, {31'd0, valid}, 32'd1);
        check_val({tag, "_data"}, rdata, exp);
        @(negedge clk);
`else
        @(negedge clk);
        check_val({tag, "_valid"}, {31'd0, valid}, 32'd1);
        check_val({tag, "_data"}, rdata, exp);
`endif
        req = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
        req   = 1'b1;
        wen   = 1'b1;
        be    = b;
        addr  = a;
        wdata = d;
        @(negedge clk);
        check_val({tag, "_novalid"}, {31'd0, valid}, 32'd0);
        req = 1'b0;
        wen = 1'b0;
        be  = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_valid", {31'd0, valid}, 32'd0);
        check_val("rst_data", rdata, 32'd0);

        // Init timing, with requests ignored during the sweep
        rst_n = 1'b1;
        wait_ready("init");

        // Init pattern (addr 9 also proves the INIT-time writes were dropped)
        do_read("rd9", 5'd9, 32'd9);
        do_read("rd7", 5'd7, 32'h0000_0007);
        do_read("rd31", 5'd31, 32'h0000_001F);

        // Byte-lane writes
        do_write("wr3", 5'd3, 4'b0010, 32'hAABB_CCDD);
        do_read("rd3", 5'd3, 32'h0000_CC03);
        do_write("wr4", 5'd4, 4'b0000, 32'hDEAD_BEEF);
        do_read("rd4", 5'd4, 32'h0000_0004);
        do_write("wr5", 5'd5, 4'b1001, 32'h1122_3344);
        do_read("rd5", 5'd5, 32'h1100_0044);

`ifndef MEMORY_ASYNC_READ_EN
        // data_o holds after the valid cycle
        @(negedge clk);
        check_val("hold_valid", {31'd0, valid}, 32'd0);
        check_val("hold_data", rdata, 32'h1100_0044);

        // Back-to-back reads
        req = 1'b1; wen = 1'b0; addr = 5'd1;
        @(negedge clk);
        check_val("pipe1_v", {31'd0, valid}, 32'd1);
        check_val("pipe1_d", rdata, 32'd1);
        addr = 5'd2;
        @(negedge clk);
        check_val("pipe2_v", {31'd0, valid}, 32'd1);
        check_val("pipe2_d", rdata, 32'd2);
        addr = 5'd3;
        @(negedge clk);
        check_val("pipe3_v", {31'd0, valid}, 32'd1);
        check_val("pipe3_d", rdata, 32'h0000_CC03);

        // Interleaved write creates a gap in valid
        addr = 5'd1;
        @(negedge clk);
        check_val("gap1_v", {31'd0, valid}, 32'd1);
        check_val("gap1_d", rdata, 32'd1);
        wen = 1'b1; be = 4'h0; addr = 5'd0;
        @(negedge clk);
        check_val("gap_v", {31'd0, valid}, 32'd0);
        wen = 1'b0; addr = 5'd2;
        @(negedge clk);
        check_val("gap2_v", {31'd0, valid}, 32'd1);
        check_val("gap2_d", rdata, 32'd2);
        req = 1'b0;
        @(negedge clk);
        check_val("gap_end_v", {31'd0, valid}, 32'd0);

        // Reset mid-read drops the pending strobe
        req = 1'b1; wen = 1'b0; addr = 5'd7;
        @(posedge clk);
        #1;
        check_val("midrd_v", {31'd0, valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("midrd_rst_v", {31'd0, valid}, 32'd0);
        check_val("midrd_rst_rdy", {31'd0, ready}, 32'd0);
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b1;
        wait_ready("rerd");
`else
        // Combinational read, zero latency
        req = 1'b1; wen = 1'b0; addr = 5'd6;
        #1;
        check_val("async6_v", {31'd0, valid}, 32'd1);
        check_val("async6_d", rdata, 32'd6);
        wen = 1'b1;
        #1;
        check_val("async_wr_v", {31'd0, valid}, 32'd0);
        req = 1'b0; wen = 1'b0;
        @(negedge clk);
`endif

        // Reset mid-INIT restarts a full sweep
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_val("midinit_rdy", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("reinit");

        // Every word equals its index again
        for (int i = 0; i < 32; i++) begin
            do_read($sformatf("sweep%0d", i), 5'(i), 32'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
